code_detector_param: RTL

Parametrised successor to the fixed Start/Red/Green/Blue door-code detector. It detects a programmable CODE_LEN-symbol sequence on an NUM_BTN-wide button bus and pulses U for exactly one cycle on a correct entry. It adds a runtime-loadable code, a failed-attempt counter and a timed lockout. It sits between the debounced button inputs and the door actuator.

---
 rtl/code_detector_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/code_detector_param.sv
// rtl/code_detector_param.sv - programmable button-sequence door-code detector with fail counter and lockout
// Optional macro CODE_DET_IDLE_HOLD_EN: all-zero Btn holds the sequence index instead of failing.
module code_detector_param #(
  parameter int NUM_BTN     = 3,
  parameter int CODE_LEN    = 4,
  parameter logic [NUM_BTN*CODE_LEN-1:0] CODE_DEFAULT = 12'h88C,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Start,
  input  logic [NUM_BTN-1:0]            Btn,
  input  logic                          Prog,
  input  logic [NUM_BTN*CODE_LEN-1:0]   Code_in,
  output logic                          U,
  output logic                          Busy,
  output logic                          Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] Fail_cnt
);

  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SEQ     = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_BTN*CODE_LEN-1:0]   code_q, code_d;
  logic [FW-1:0]                 fail_q, fail_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic                          u_q, u_d;
  logic                          busy_q, busy_d;
  logic                          locked_q, locked_d;
  logic [NUM_BTN-1:0]            exp_sym;
  logic                          hold;

  always_comb begin
    exp_sym = code_q[NUM_BTN-1:0];
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IW'(i)) exp_sym = code_q[i*NUM_BTN +: NUM_BTN];
    end
  end

`ifdef CODE_DET_IDLE_HOLD_EN
  // Released buttons between presses wait for the next symbol rather than failing.
  assign hold = (Btn == '0) && (exp_sym != '0);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      ST_WAIT: begin
        if (Prog) begin
          code_d = Code_in;
        end else if (Start) begin
          state_d = ST_SEQ;
          idx_d   = '0;
        end
      end
      ST_SEQ: begin
        if (hold) begin
          idx_d = idx_q;
        end else if (Btn == exp_sym) begin
          if (idx_q == IW'(CODE_LEN - 1)) begin
            state_d = ST_OPEN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          idx_d = '0;
          if (int'(fail_q) < MAX_FAIL) fail_d = fail_q + 1'b1;
          if (int'(fail_q) + 1 >= MAX_FAIL) begin
            state_d = ST_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYC);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_OPEN: begin
        state_d = ST_WAIT;
        fail_d  = '0;
      end
      ST_LOCKOUT: begin
        // Leaving on timer==1 keeps Locked high for exactly LOCKOUT_CYC cycles.
        if (timer_q <= TW'(1)) begin
          state_d = ST_WAIT;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
    u_d      = (state_d == ST_OPEN);
    busy_d   = (state_d == ST_SEQ);
    locked_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_WAIT;
      idx_q    <= '0;
      code_q   <= CODE_DEFAULT;
      fail_q   <= '0;
      timer_q  <= '0;
      u_q      <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      u_q      <= u_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  assign U        = u_q;
  assign Busy     = busy_q;
  assign Locked   = locked_q;
  assign Fail_cnt = fail_q;

endmodule
